// File: rtl/bus_demux4.sv
// ---------------------------------------------------------------------------
// bus_demux4 -- 1-to-4 request router for the CPU data-side SRAM-like bus.
//
// A single master request stream is steered to one of four slaves (data RAM,
// confreg, timer, spare). The slave is chosen by the 2-bit address field
// m_addr[SEL_LSB+1:SEL_LSB]. The selected slave's response is registered and
// returned to the master one cycle later. Only one transaction can be
// outstanding at a time.
//
// Optional feature (macro BUS_DEMUX4_TIMEOUT_EN):
//   A response watchdog. If the slave does not answer within TIMEOUT cycles,
//   a dummy response is returned (32'hDEAD_BEEF for DW=32, all-ones
//   otherwise) and the sticky err flag is set. Without the macro, RESP
//   waits forever and err is tied low.
//
// Ports:
//   clk, resetn                : clock, asynchronous active-low reset
//   m_req/m_wr/m_addr/
//   m_wstrb/m_wdata            : master request (m_req held until m_addr_ok)
//   m_addr_ok                  : request accepted this cycle
//   m_data_ok/m_rdata          : one-cycle response pulse and read data
//   s_req[3:0]                 : one-hot per-slave request
//   s_wr/s_addr/s_wstrb/s_wdata: broadcast copies of the master fields
//   s_addr_ok[3:0]             : per-slave accept
//   s_data_ok[3:0]             : per-slave response pulse
//   s_rdata[4*DW-1:0]          : packed read data, slave i at [i*DW +: DW]
//   busy                       : a transaction is outstanding
//   err                        : sticky response-timeout flag
// ---------------------------------------------------------------------------
module bus_demux4 #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int SEL_LSB = 16,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              m_req,
    input  logic              m_wr,
    input  logic [AW-1:0]     m_addr,
    input  logic [DW/8-1:0]   m_wstrb,
    input  logic [DW-1:0]     m_wdata,
    output logic              m_addr_ok,
    output logic              m_data_ok,
    output logic [DW-1:0]     m_rdata,
    output logic [3:0]        s_req,
    output logic              s_wr,
    output logic [AW-1:0]     s_addr,
    output logic [DW/8-1:0]   s_wstrb,
    output logic [DW-1:0]     s_wdata,
    input  logic [3:0]        s_addr_ok,
    input  logic [3:0]        s_data_ok,
    input  logic [4*DW-1:0]   s_rdata,
    output logic              busy,
    output logic              err
);

    // Parameter sanity checks at elaboration.
    if (SEL_LSB + 1 >= AW) begin : g_bad_sel_lsb
        $error("bus_demux4: SEL_LSB+1 must be below AW");
    end
    if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("bus_demux4: TIMEOUT must be within 1..65535");
    end

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      cur_sel_q, cur_sel_d;
    logic            m_data_ok_q, m_data_ok_d;
    logic [DW-1:0]   m_rdata_q, m_rdata_d;

    logic [1:0]      sel;
    logic            accept;
    logic [DW-1:0]   rdata_arr [4];

`ifdef BUS_DEMUX4_TIMEOUT_EN
    localparam int            CNT_W   = 16;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [DW-1:0] TO_DATA = (DW == 32) ? DW'(32'hDEAD_BEEF) : {DW{1'b1}};

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
`endif

    // Unpack the slave read-data bus so it can be indexed by a select value.
    for (genvar i = 0; i < 4; i++) begin : g_rdata
        assign rdata_arr[i] = s_rdata[i*DW +: DW];
    end

    assign sel    = m_addr[SEL_LSB+1:SEL_LSB];
    assign accept = (state_q == IDLE) && m_req && s_addr_ok[sel];

    // Request fields are broadcast; only the selected slave sees s_req.
    assign s_req     = (state_q == IDLE && m_req) ? (4'b0001 << sel) : 4'b0000;
    assign s_wr      = m_wr;
    assign s_addr    = m_addr;
    assign s_wstrb   = m_wstrb;
    assign s_wdata   = m_wdata;

    assign m_addr_ok = accept;
    assign m_data_ok = m_data_ok_q;
    assign m_rdata   = m_rdata_q;
    assign busy      = (state_q == RESP);

`ifdef BUS_DEMUX4_TIMEOUT_EN
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        cur_sel_d   = cur_sel_q;
        m_data_ok_d = 1'b0;         // response is a single-cycle pulse
        m_rdata_d   = m_rdata_q;
`ifdef BUS_DEMUX4_TIMEOUT_EN
        cnt_d       = cnt_q;
        err_d       = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    cur_sel_d = sel;
                    // A slave that answers in the accept cycle completes the
                    // transaction immediately, so RESP is skipped.
                    if (s_data_ok[sel]) begin
                        m_data_ok_d = 1'b1;
                        m_rdata_d   = rdata_arr[sel];
                    end else begin
                        state_d = RESP;
`ifdef BUS_DEMUX4_TIMEOUT_EN
                        cnt_d   = '0;
`endif
                    end
                end
            end
            RESP: begin
                // data_ok from any other slave is deliberately ignored.
                if (s_data_ok[cur_sel_q]) begin
                    m_data_ok_d = 1'b1;
                    m_rdata_d   = rdata_arr[cur_sel_q];
                    state_d     = IDLE;
`ifdef BUS_DEMUX4_TIMEOUT_EN
                end else if (cnt_q == CNT_LAST) begin
                    // Abandon the slave; a late data_ok lands in IDLE
                    // without an accept and is dropped.
                    m_data_ok_d = 1'b1;
                    m_rdata_d   = TO_DATA;
                    err_d       = 1'b1;
                    state_d     = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            cur_sel_q   <= 2'd0;
            m_data_ok_q <= 1'b0;
            m_rdata_q   <= '0;
`ifdef BUS_DEMUX4_TIMEOUT_EN
            cnt_q       <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cur_sel_q   <= cur_sel_d;
            m_data_ok_q <= m_data_ok_d;
            m_rdata_q   <= m_rdata_d;
`ifdef BUS_DEMUX4_TIMEOUT_EN
            cnt_q       <= cnt_d;
            err_q       <= err_d;
`endif
        end
    end

endmodule
